// File: rtl/led_cube_frame_buffer.sv
// rtl/led_cube_frame_buffer.sv - double-buffered 64-byte frame store for the LED cube driver
//
// Purpose:
//   Stores one frame per bank. The source writes bytes into the back bank over
//   a valid/ready handshake. The frame driver reads the front bank by address.
//   The banks swap only when the back bank holds a complete frame and the
//   driver signals a frame boundary. A frame is therefore never shown half-written.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     source presents a byte
//   in_data      byte to store
//   in_sof       marks in_data as byte 0 of a frame (resync)
//   in_ready     block accepts a byte this cycle (state FILL)
//   frame_done   one-cycle pulse from the driver: swap permitted
//   rd_addr      driver read address
//   rd_data      registered front-bank byte (0 while no frame is shown)
//   frame_ready  back bank complete, waiting for a swap
//   front_valid  front bank holds a complete frame
//   sync_err     one-cycle pulse: in_sof accepted with write pointer != 0
//   swap_count   swaps since reset, wraps at 16 bits

module led_cube_frame_buffer #(
  parameter int FRAME_BYTES = 64,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_sof,
  output logic              in_ready,
  input  logic              frame_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_ready,
  output logic              front_valid,
  output logic              sync_err,
  output logic [15:0]       swap_count
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_wptr;
  logic              r_front_sel;
  logic              r_front_valid;
  logic              r_sync_err;
  logic [15:0]       r_swap_count;
  logic [7:0]        r_rd_data;

  logic [7:0]        r_bank0 [FRAME_BYTES];
  logic [7:0]        r_bank1 [FRAME_BYTES];

  logic              w_in_ready;
  logic              w_frame_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_swap;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [7:0]        w_front_byte;

  // A start-of-frame byte always lands at address 0, whatever the pointer holds.
  assign w_accept  = in_valid & w_in_ready;
  assign w_wr_addr = in_sof ? '0 : r_wptr;
  // A sof byte can never be the last byte. The frame has more than one byte.
  assign w_last    = w_accept & ~in_sof & (r_wptr == ADDR_W'(FRAME_BYTES - 1));
  // frame_done counts only in FULL. In FILL the driver repeats the current front frame.
  assign w_swap    = (r_state == S_FULL) & frame_done;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The handshake outputs decode from the state register only.
  always_comb begin
    w_state_nxt   = r_state;
    w_in_ready    = 1'b0;
    w_frame_ready = 1'b0;
    case (r_state)
      S_FILL: begin
        w_in_ready = 1'b1;
        // If the last byte and frame_done arrive together, the byte wins.
        // The swap then waits for the next frame_done.
        if (w_last) begin
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        w_frame_ready = 1'b1;
        if (frame_done) begin
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr        <= '0;
      r_front_sel   <= 1'b0;
      r_front_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_swap_count  <= '0;
    end else begin
      // A sof that lands mid-frame drops the partial frame. The bytes already
      // written are overwritten as the new frame fills.
      r_sync_err <= w_accept & in_sof & (r_wptr != '0);

      if (w_accept) begin
        if (in_sof) begin
          r_wptr <= ADDR_W'(1);
        end else if (w_last) begin
          r_wptr <= '0;
        end else begin
          r_wptr <= r_wptr + ADDR_W'(1);
        end
      end

      if (w_swap) begin
        r_front_sel   <= ~r_front_sel;
        r_front_valid <= 1'b1;
        r_swap_count  <= r_swap_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------- storage
  // The back bank is the one front_sel does not point at. Writes happen only
  // in FILL and swaps only in FULL, so a bank is never read and written as
  // front in the same cycle.
  always_ff @(posedge clk) begin
    if (w_accept && r_front_sel) begin
      r_bank0[w_wr_addr] <= in_data;
    end
    if (w_accept && !r_front_sel) begin
      r_bank1[w_wr_addr] <= in_data;
    end
  end

  assign w_front_byte = r_front_sel ? r_bank1[rd_addr] : r_bank0[rd_addr];

  // Bank contents are undefined after reset. front_valid masks them until the
  // first complete frame has been swapped in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_front_valid ? w_front_byte : 8'h00;
    end
  end

  assign in_ready    = w_in_ready;
  assign frame_ready = w_frame_ready;
  assign front_valid = r_front_valid;
  assign sync_err    = r_sync_err;
  assign swap_count  = r_swap_count;
  assign rd_data     = r_rd_data;

endmodule

// File: doc/led_cube_frame_buffer.md
# led_cube_frame_buffer

Double-buffered 64-byte frame store that sits between the byte-stream source (host/UART/Avalon side) and the LED cube single-frame driver. It accepts one byte per cycle over a valid/ready handshake into a back bank, and serves the driver's address-indexed reads from a front bank. Banks swap only at a driver frame boundary, so a frame is never displayed half-written.

## Interface
- FRAME_BYTES, 64, bytes per frame (8 layers x 8 latches); must equal 2**ADDR_W
- ADDR_W, 6, frame address width
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  source presents a byte
- in_data  in  8  byte to store
- in_sof  in  1  qualifies in_data as byte 0 of a frame (resync marker)
- in_ready  out  1  block can accept a byte this cycle
- frame_done  in  1  single-cycle pulse from the frame driver: current frame finished, swap permitted
- rd_addr  in  ADDR_W  driver read address
- rd_data  out  8  front-bank byte at rd_addr, registered
- frame_ready  out  1  back bank holds a complete frame awaiting swap
- front_valid  out  1  front bank holds a complete frame (0 until first swap)
- sync_err  out  1  one-cycle pulse: in_sof accepted while write pointer != 0
- swap_count  out  16  number of swaps since reset, wraps at 0xFFFF -> 0

## Operation
- Storage: two banks, FRAME_BYTES x 8. front_sel (internal) selects the bank read; the other bank is written.
- States: FILL, FULL. Reset -> FILL, wptr=0, front_sel=0, front_valid=0.
- FILL: in_ready=1. Accept = in_valid & in_ready. On accept, write in_data to back[wptr].
  - in_sof on accept: byte written at address 0, wptr <= 1; if wptr was != 0, sync_err pulses next cycle (partial frame discarded, not swapped).
  - Otherwise wptr <= wptr+1. When the accepted byte is at address FRAME_BYTES-1: wptr <= 0, state -> FULL.
- FULL: in_ready=0, frame_ready=1, back bank frozen.
  - frame_done: front_sel toggles, front_valid <= 1, swap_count increments, state -> FILL.
- frame_done in FILL: ignored (driver repeats the current front frame).
- Last-byte accept and frame_done in the same cycle: byte stored, state -> FULL; no swap that cycle, swap waits for the next frame_done.
- Read: rd_data <= front_valid ? front[rd_addr] : 8'h00, every cycle regardless of state.
- rd_addr width arithmetic: wptr is ADDR_W bits, wraps naturally at FRAME_BYTES.
- Reset mid-fill or mid-FULL: all state returns to reset values; bank contents are undefined but masked by front_valid=0.

## Timing
- Reset values: in_ready=1 (once rst_n is high, state FILL), rd_data=0, frame_ready=0, front_valid=0, sync_err=0, swap_count=0.
- in_ready and frame_ready decode directly from the state register; no combinational path from in_valid or frame_done.
- Write: 1 byte/cycle sustained; a full frame fills in exactly FRAME_BYTES accept cycles.
- FULL is entered on the edge that accepts byte 63; in_ready is 0 in the following cycle.
- Swap: frame_done sampled at edge N; front_sel/front_valid/swap_count update at edge N; rd_addr presented after edge N returns new-bank data at edge N+1.
- Read latency: 1 cycle from rd_addr to rd_data.
- First new frame after swap: back bank accepts bytes starting the cycle after edge N (in_ready=1).

## Test plan
- Reset, then rd_addr sweep 0..63 -> rd_data=0x00 every cycle; in_ready=1, frame_ready=0, swap_count=0.
- Stream 64 bytes 0x00..0x3F (sof on first), no frame_done -> frame_ready=1, in_ready=0; rd_data still 0x00; pulse frame_done -> front_valid=1, swap_count=1; rd_addr=0x2A returns 0x2A one cycle later.
- Fill bank B with 0xFF-addr while frame A displays; pulse frame_done mid-fill (byte 20) -> no swap, rd_addr=5 still returns 0x05; after completion and next frame_done rd_addr=5 returns 0xFA, swap_count=2.
- Send 10 bytes, then in_sof with 0xAA -> sync_err one-cycle pulse; 63 more bytes complete frame; after swap rd_addr=0 returns 0xAA.
- Accept byte 63 in the same cycle as frame_done -> state FULL, no swap, swap_count unchanged; next frame_done swaps.
- Assert rst_n low asynchronously mid-fill (byte 30) -> outputs return to reset values immediately, front_valid=0, rd_data=0x00 on next edge; refill completes normally.
